// File: rtl/frame_1011_pkg.sv
// Shared types and constants for the 1011-sync serial framer.
// Holds the FSM encoding, the sync word and the counter sizing helper.
package frame_1011_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b1011;
  localparam int         SYNC_LEN     = 4;

  // Counter must index both the payload and the gap/sync phases, so never below 4 bits.
  function automatic int cnt_width(input int data_w);
    return ($clog2(data_w) > 4) ? $clog2(data_w) : 4;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, MSB first; load wins over shift.
// Zero latency on the msb tap; no backpressure, the owner sequences load/shift.
module piso_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data_in,
  output logic         msb
);

  logic [W-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data_in;
    end else if (shift) begin
      sreg <= {sreg[W-2:0], 1'b0};
    end
  end

  assign msb = sreg[W-1];

endmodule

// File: rtl/frame_1011_tx.sv
// Serialises one payload per frame as 1011 sync, DATA_W bits MSB first, then GAP_LEN zeros.
// First sync bit appears the cycle after acceptance; in_ready is low for the whole frame and gap.
module frame_1011_tx
  import frame_1011_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GAP_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  output logic              d_out,
  output logic              frame_active,
  output logic              done
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
  logic             d_nxt, active_nxt, done_nxt;
  logic             load_en, shift_en, sreg_msb;

  piso_shreg #(.W(DATA_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load_en),
    .shift   (shift_en),
    .data_in (data_in),
    .msb     (sreg_msb)
  );

  assign in_ready = (state == IDLE);
  assign cnt_dec  = cnt - CNT_W'(1);

  // Outputs are computed for the state being entered, so d_out lines up with state.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    d_nxt      = 1'b0;
    active_nxt = 1'b0;
    done_nxt   = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt  = SYNC;
          cnt_nxt    = SYNC_LAST;
          d_nxt      = SYNC_PATTERN[SYNC_LEN-1];
          active_nxt = 1'b1;
          load_en    = 1'b1;
        end
      end
      SYNC: begin
        active_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = DATA;
          cnt_nxt   = DATA_LAST;
          d_nxt     = sreg_msb;
          shift_en  = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
          d_nxt   = SYNC_PATTERN[cnt_dec[1:0]];
        end
      end
      DATA: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LAST;
        end else begin
          cnt_nxt    = cnt_dec;
          d_nxt      = sreg_msb;
          shift_en   = 1'b1;
          active_nxt = 1'b1;
          done_nxt   = (cnt == CNT_W'(1));
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      d_out        <= 1'b0;
      frame_active <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      d_out        <= d_nxt;
      frame_active <= active_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_1011_tx.sv
// Bench for frame_1011_tx: frame-level scoreboard, vector table, corner sequences,
// a 1011 loopback receiver and the DATA_W=8 / GAP_LEN=1 variant.
module tb_frame_1011_tx;

  localparam int W = 16;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         in_ready, d_out, frame_active, done;

  logic         v_valid = 1'b0;
  logic [7:0]   v_data = '0;
  logic         v_ready, v_d, v_fa, v_done;

  frame_1011_tx #(.DATA_W(W), .GAP_LEN(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .in_ready(in_ready), .d_out(d_out), .frame_active(frame_active), .done(done)
  );

  frame_1011_tx #(.DATA_W(8), .GAP_LEN(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v_valid), .data_in(v_data),
    .in_ready(v_ready), .d_out(v_d), .frame_active(v_fa), .done(v_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic fa;
    logic dn;
  } exp_t;

  typedef struct {
    logic [W-1:0] data;
    logic [19:0]  bits;
  } vec_t;

  exp_t         q[$];
  logic [W-1:0] sent[$];
  vec_t         vt[5];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           accepts = 0;
  bit           rx_en = 1'b0;
  bit           cap = 1'b0;
  logic [3:0]   hist = '0;
  logic [W-1:0] rxw = '0;
  int           nb = 0;
  int           rx_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected line content for one whole frame, one entry per cycle.
  task automatic push_frame(input logic [W-1:0] p);
    logic [3:0] sp;
    sp = 4'b1011;
    for (int i = 3; i >= 0; i--) q.push_back('{sp[i], 1'b1, 1'b0});
    for (int i = W - 1; i >= 0; i--) q.push_back('{p[i], 1'b1, (i == 0)});
    for (int i = 0; i < G; i++) q.push_back('{1'b0, 1'b0, 1'b0});
  endtask

  task automatic observe();
    exp_t e;
    logic er;
    logic [W-1:0] want;
    e  = (q.size() > 0) ? q[0] : '0;
    er = (q.size() == 0);
    chk("scoreboard", {28'd0, d_out, frame_active, done, in_ready}, {28'd0, e.d, e.fa, e.dn, er});
    if (rx_en) begin
      if (!cap) begin
        hist = {hist[2:0], d_out};
        if (hist == 4'b1011 && frame_active) begin
          cap  = 1'b1;
          nb   = 0;
          hist = '0;
        end
      end else begin
        rxw = {rxw[W-2:0], d_out};
        nb++;
        if (nb == W) begin
          cap = 1'b0;
          rx_frames++;
          want = (sent.size() > 0) ? sent.pop_front() : ~rxw;
          chk("loopback", {16'd0, rxw}, {16'd0, want});
        end
      end
    end
  endtask

  task automatic tick();
    bit acc;
    acc = in_valid && (q.size() == 0) && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        push_frame(data_in);
        accepts++;
        if (rx_en) sent.push_back(data_in);
      end
    end
    #1;
    cyc++;
    observe();
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int fa_cnt;
    int t;
    int a0;
    logic prev;
    logic dn_seen;
    logic [12:0] vexp;

    vt[0] = '{16'hA5C3, 20'hBA5C3};
    vt[1] = '{16'h0000, 20'hB0000};
    vt[2] = '{16'hBBBB, 20'hBBBBB};
    vt[3] = '{16'hFFFF, 20'hBFFFF};
    vt[4] = '{16'h8001, 20'hB8001};

    // Reset state
    rst = 1'b1;
    in_valid = 1'b1;
    data_in = 16'h5555;
    tick();
    tick();
    chk("reset_outs", {29'd0, d_out, frame_active, done}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_ready8", {31'd0, v_ready}, 32'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Vector table: full frame timeline per payload
    for (int v = 0; v < 5; v++) begin
      in_valid = 1'b1;
      data_in = vt[v].data;
      tick();
      in_valid = 1'b0;
      data_in = ~vt[v].data;
      fa_cnt = 0;
      for (int k = 0; k < 24; k++) begin
        chk("table_d", {31'd0, d_out}, {31'd0, (k < 20) ? vt[v].bits[19-k] : 1'b0});
        chk("table_done", {31'd0, done}, {31'd0, (k == 19)});
        chk("table_busy", {31'd0, in_ready}, 32'd0);
        fa_cnt += int'(frame_active);
        tick();
      end
      chk("table_fa_len", fa_cnt, 20);
      chk("table_ready", {31'd0, in_ready}, 32'd1);
    end

    // Held request: second frame starts 25 cycles after the first
    in_valid = 1'b1;
    data_in = 16'h1234;
    tick();
    data_in = 16'hFFFF;
    t = 0;
    prev = frame_active;
    for (int i = 0; i < 40; i++) begin
      tick();
      t++;
      if (frame_active && !prev) break;
      prev = frame_active;
    end
    chk("held_spacing", t, 25);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    tick();

    // Reset during data bit 7
    in_valid = 1'b1;
    data_in = 16'hA5C3;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("rst_mid_outs", {29'd0, d_out, frame_active, done}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    dn_seen = 1'b0;
    repeat (30) begin
      tick();
      dn_seen |= done;
    end
    chk("rst_mid_no_done", {31'd0, dn_seen}, 32'd0);

    // Narrow variant: 8-bit payload, single gap cycle
    v_valid = 1'b1;
    v_data = 8'h81;
    tick();
    v_valid = 1'b0;
    v_data = 8'h7E;
    vexp = 13'b1011_10000001_0;
    for (int k = 0; k < 13; k++) begin
      chk("var_d", {31'd0, v_d}, {31'd0, vexp[12-k]});
      chk("var_done", {31'd0, v_done}, {31'd0, (k == 11)});
      chk("var_fa", {31'd0, v_fa}, {31'd0, (k < 12)});
      chk("var_busy", {31'd0, v_ready}, 32'd0);
      tick();
    end
    chk("var_ready_14", {31'd0, v_ready}, 32'd1);

    // Random traffic through a 1011 loopback receiver
    rx_en = 1'b1;
    cap = 1'b0;
    hist = '0;
    a0 = accepts;
    for (int i = 0; i < 6000 && (accepts - a0) < 100; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      data_in = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (40) tick();
    chk("rand_frames", rx_frames, 100);
    chk("rand_sent_left", sent.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_1011_tx.md
FRAME_1011_TX -- requirements
Module: frame_1011_tx

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, payload width in bits.
REQ-002 SHALL provide parameter GAP_LEN, default 4, count of forced-zero cycles after each frame; legal range 1..15.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  payload offered on data_in.
REQ-006 SHALL provide port data_in  input  DATA_W  parallel payload.
REQ-007 SHALL provide port in_ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL provide port d_out  output  1  registered serial line.
REQ-009 SHALL provide port frame_active  output  1  high while a sync or data bit is on d_out.
REQ-010 SHALL provide port done  output  1  single-cycle pulse while the last data bit is on d_out.

Function
REQ-011 SHALL use the four states IDLE, SYNC, DATA and GAP.
REQ-012 SHALL drive in_ready high only in IDLE, decoded from state.
REQ-013 SHALL accept a payload on a rising edge where in_valid and in_ready are both high, capturing data_in into a DATA_W shift register and entering SYNC.
REQ-014 SHALL drive d_out = 1,0,1,1 in the four cycles after acceptance (SYNC), then enter DATA.
REQ-015 SHALL drive the payload MSB first for DATA_W cycles in DATA, then enter GAP.
REQ-016 SHALL hold d_out = 0 for GAP_LEN cycles in GAP, then enter IDLE.
REQ-017 SHALL give a fixed timeline for acceptance at edge N: sync bits on cycles N+1..N+4, data on N+5..N+4+DATA_W, gap on the following GAP_LEN cycles, and in_ready high again on the next cycle.
REQ-018 SHALL drive d_out = 0 in IDLE and GAP.
REQ-019 SHALL drive frame_active high exactly in SYNC and DATA.
REQ-020 SHALL ignore in_valid and data_in outside IDLE; a held payload is accepted on the first IDLE cycle.
REQ-021 SHALL leave an in-flight frame unaffected by changes on data_in after acceptance.
REQ-022 SHALL use one shared bit counter with width clog2(DATA_W) of at least 4 bits, reloaded on each state entry and never wrapping inside a state.
REQ-023 SHALL NOT escape payload bits; a 1011 inside the payload is transmitted unchanged.
REQ-024 SHALL send a DATA_W-bit stream of all zeros when DATA_W'h0 is accepted, with done still pulsing.
REQ-025 SHALL send any unreachable state to IDLE on the next edge.

Reset
REQ-026 SHALL, on any edge with rst high, set state IDLE, d_out 0, frame_active 0, done 0, shift register 0 and counter 0.
REQ-027 SHALL abort any frame when rst is asserted, SYNC/DATA/GAP included, with no completion of remaining bits.
REQ-028 SHALL ignore in_valid on edges with rst high.
REQ-029 SHALL present in_ready high on the first cycle after rst deasserts.

Structure
REQ-030 SHALL place the state enum, SYNC_PATTERN = 4'b1011 and SYNC_LEN = 4 in shared package frame_1011_pkg.
REQ-031 SHALL implement the payload shift register as sub-module piso_shreg (parallel load, shift-left enable, MSB output).
REQ-032 SHALL keep the FSM and counter in frame_1011_tx, with d_out registered.

Verification
REQ-033 SHALL cover a single frame: data_in=16'hA5C3 accepted at edge N -> d_out 1011 then 1010010111000011 on N+1..N+20, done at N+20, 0 for 4 cycles, in_ready high at N+25.
REQ-034 SHALL cover a held request: in_valid held high with 16'h1234 then 16'hFFFF -> second frame sync starts exactly 25 cycles after the first; no payload mixing.
REQ-035 SHALL cover reset mid-frame: rst high for 1 cycle during data bit 7 -> next cycle d_out=0, frame_active=0, done never pulses, in_ready=1 after deassert.
REQ-036 SHALL cover an embedded pattern: data_in=16'hBBBB -> payload sent verbatim as 1011 x4, frame_active high 20 cycles.
REQ-037 SHALL cover a loopback check: d_out into a 1011 Moore detector -> detection at sync end, sampled payload equals data_in for 100 random frames.
REQ-038 SHALL cover the parameter variant DATA_W=8, GAP_LEN=1 with 8'h81 -> 10111000 0001, then one 0, in_ready high 14 cycles after accept.
